rsa_exp_ctrl: RTL and testbench
===============================

// Module: rsa_exp_ctrl
// PURPOSE
//  Sequences one RSA modular exponentiation S = Y^D mod N (LSB-first square-and-multiply).
//  Starts the preprocess unit to get T = Y*2^WIDTH mod N.
//  Then time-shares one external Montgomery multiplier, MP(a,b) = a*b*2^-WIDTH mod N,
//  between the multiply step and the square step of every exponent bit.
//  Sits between the top-level RSA wrapper and the preprocess/Montgomery datapaths.
// PARAMETERS
//  WIDTH     256  operand width (N, Y, D, results)
//  EXP_BITS  256  exponent bits processed, bit 0 first
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-low reset
//  start     in   1      request; accepted only in IDLE
//  N_i       in   WIDTH  modulus (odd, > 1)
//  Y_i       in   WIDTH  base (< N)
//  D_i       in   WIDTH  exponent
//  result_o  out  WIDTH  Y^D mod N; held until next accepted start
//  busy      out  1      high from the cycle after start acceptance until done
//  done      out  1      one-cycle pulse when result_o becomes valid
//  pp_start  out  1      one-cycle start pulse to preprocess unit
//  pp_M      out  WIDTH  latched Y, to preprocess unit
//  pp_T_i    in   WIDTH  preprocess result
//  pp_finish in   1      preprocess finished (level; also high while that unit idles)
//  mm_start  out  1      one-cycle start pulse to Montgomery multiplier
//  mm_a      out  WIDTH  multiplier operand a; stable while an operation is outstanding
//  mm_b      out  WIDTH  multiplier operand b; stable while an operation is outstanding
//  mm_p_i    in   WIDTH  multiplier result
//  mm_done   in   1      multiplier result valid (sampled only while waiting)
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=IDLE. All outputs, S, T, bit counter and latches = 0.
//  Start acceptance (IDLE & start): latch N_i, Y_i, D_i. Set S=1, cnt=0. pp_M=Y. Go to PREP.
//   - Input changes after acceptance have no effect.
//   - start outside IDLE is ignored.
//  PREP: pp_start=1 for exactly one cycle (the first PREP cycle).
//   - pp_finish is ignored in that cycle; it is sampled from the next cycle on.
//   - On pp_finish=1: T=pp_T_i, go to BIT.
//  BIT (1 cycle): if D[cnt]=1 go to MUL, else go to SQR.
//   - Exception: when cnt=EXP_BITS-1 and D[cnt]=0, go to FIN.
//  MUL: mm_a=S, mm_b=T, mm_start pulse. Wait for mm_done, then S=mm_p_i.
//   - If cnt=EXP_BITS-1, go to FIN; else go to SQR.
//  SQR: mm_a=T, mm_b=T, mm_start pulse. Wait for mm_done, then T=mm_p_i, cnt=cnt+1, go to BIT.
//  The square of the last bit is skipped.
//  Multiplier operations: exactly popcount(D) multiplies + (EXP_BITS-1) squares.
//  FIN: result_o=S, done=1 for one cycle, busy=0, go to IDLE.
//   - done is asserted the cycle after the final mm_done is sampled (or the cycle after BIT for D[last]=0).
//   - A start in the cycle done is high is not accepted; it is accepted from the following cycle.
//  Only one multiplier operation is outstanding at a time.
//  mm_done outside a wait state is ignored.
//  Widths: S and T are WIDTH bits; cnt is clog2(EXP_BITS) bits and does not wrap (terminates at EXP_BITS-1).
//  Mid-operation reset: aborts immediately. No pulses are emitted after reset rises again until a new start.
// TESTING  (behavioural preprocess model: 257-cycle latency; Montgomery model: 40-cycle latency, exact MP)
//  1. N=143, Y=2, D=7 -> result_o=128, done after 3 mul + 255 sqr ops, busy low same cycle as done.
//  2. N=143, Y=142, D=2 -> result_o=1; exactly 1 mm_start with mm_a!=mm_b (multiply step).
//  3. D=0, any Y -> result_o=1; 0 multiplies, 255 squares, single done pulse.
//  4. D=all ones, random 256-bit odd N, Y<N -> 511 mm_start pulses; result equals golden model.
//  5. start re-pulsed and N_i/Y_i/D_i changed mid-run -> ignored; result from the original operands.
//  6. reset=0 during a SQR wait -> all outputs 0 asynchronously; a new start yields a correct result.

Source files
------------

// File: rtl/rsa_exp_ctrl.sv
// Sequencer for one RSA modular exponentiation S = Y^D mod N (LSB-first square-and-multiply).
// Drives a preprocess unit once, then alternates one shared Montgomery multiplier between multiply and square steps.
module rsa_exp_ctrl #(
  parameter int WIDTH    = 256,
  parameter int EXP_BITS = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] N_i,
  input  logic [WIDTH-1:0] Y_i,
  input  logic [WIDTH-1:0] D_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy,
  output logic             done,
  output logic             pp_start,
  output logic [WIDTH-1:0] pp_M,
  input  logic [WIDTH-1:0] pp_T_i,
  input  logic             pp_finish,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  input  logic [WIDTH-1:0] mm_p_i,
  input  logic             mm_done,
  output logic [3:0]       state_o
);

  localparam int CW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PREP      = 4'd1,
    S_PREP_WAIT = 4'd2,
    S_BIT       = 4'd3,
    S_MUL       = 4'd4,
    S_MUL_WAIT  = 4'd5,
    S_SQR       = 4'd6,
    S_SQR_WAIT  = 4'd7,
    S_FIN       = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d, y_q, y_d, d_q, d_d;
  logic [WIDTH-1:0] s_q, s_d, t_q, t_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;
  logic             n_unused;

  // N is only carried for the datapaths fed by the wrapper; this controller never reads it.
  assign n_unused = ^n_q;
  assign last_bit = (cnt_q == CW'(EXP_BITS - 1));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    y_d     = y_q;
    d_d     = d_q;
    s_d     = s_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = N_i;
          y_d     = Y_i;
          d_d     = D_i;
          s_d     = WIDTH'(1);
          cnt_d   = '0;
          state_d = S_PREP;
        end
      end
      S_PREP: state_d = S_PREP_WAIT;
      S_PREP_WAIT: begin
        if (pp_finish) begin
          t_d     = pp_T_i;
          state_d = S_BIT;
        end
      end
      S_BIT: begin
        if (d_q[cnt_q]) begin
          a_d     = s_q;
          b_d     = t_q;
          state_d = S_MUL;
        end else if (last_bit) begin
          res_d   = s_q;
          state_d = S_FIN;
        end else begin
          a_d     = t_q;
          b_d     = t_q;
          state_d = S_SQR;
        end
      end
      S_MUL: state_d = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if (mm_done) begin
          s_d = mm_p_i;
          // The square after the final exponent bit would be wasted work.
          if (last_bit) begin
            res_d   = mm_p_i;
            state_d = S_FIN;
          end else begin
            a_d     = t_q;
            b_d     = t_q;
            state_d = S_SQR;
          end
        end
      end
      S_SQR: state_d = S_SQR_WAIT;
      S_SQR_WAIT: begin
        if (mm_done) begin
          t_d     = mm_p_i;
          cnt_d   = cnt_q + CW'(1);
          state_d = S_BIT;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      s_q     <= '0;
      t_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      y_q     <= y_d;
      d_q     <= d_d;
      s_q     <= s_d;
      t_q     <= t_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  // Start pulses come from the one-cycle issue states, so they cannot repeat while an op is outstanding.
  assign pp_start = (state_q == S_PREP);
  assign mm_start = (state_q == S_MUL) || (state_q == S_SQR);
  assign done     = (state_q == S_FIN);
  assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
  assign pp_M     = y_q;
  assign mm_a     = a_q;
  assign mm_b     = b_q;
  assign result_o = res_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Randomized bench for rsa_exp_ctrl with behavioural preprocess/Montgomery units and a modexp reference.
module tb_rsa_exp_ctrl;
  localparam int W      = 256;
  localparam int EB     = 256;
  localparam int PP_LAT = 257;
  localparam int MM_LAT = 40;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] n_in = '0, y_in = '0, d_in = '0;
  logic [W-1:0] result_o, pp_M, pp_T, mm_a, mm_b, mm_p;
  logic         busy, done, pp_start, pp_finish, mm_start, mm_done;
  logic [3:0]   state_o;

  rsa_exp_ctrl #(.WIDTH(W), .EXP_BITS(EB)) dut (
    .clk(clk), .reset(rst_n), .start(start),
    .N_i(n_in), .Y_i(y_in), .D_i(d_in),
    .result_o(result_o), .busy(busy), .done(done),
    .pp_start(pp_start), .pp_M(pp_M), .pp_T_i(pp_T), .pp_finish(pp_finish),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_p_i(mm_p), .mm_done(mm_done),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int ops_q[$];
  int diff_q[$];
  logic [W-1:0] cur_n = '0, cur_y = '0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, b, n);
    logic [2*W-1:0] p, r;
    p = (2*W)'(a) * (2*W)'(b);
    r = p % (2*W)'(n);
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_exp(input logic [W-1:0] y, d, n);
    logic [W-1:0] r;
    r = W'(1);
    for (int i = W - 1; i >= 0; i--) begin
      r = mod_mul(r, r, n);
      if (d[i]) r = mod_mul(r, y, n);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pre_t(input logic [W-1:0] y, n);
    logic [2*W-1:0] p, r;
    p = {y, {W{1'b0}}};
    r = p % (2*W)'(n);
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, b, n);
    logic [W+1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + (W+2)'(b);
      if (t[0]) t = t + (W+2)'(n);
      t = t >> 1;
    end
    if (t >= (W+2)'(n)) t = t - (W+2)'(n);
    return t[W-1:0];
  endfunction

  // ---------------- behavioural preprocess unit ----------------
  logic         pp_busy;
  int           pp_cnt;
  logic [W-1:0] pp_m_lat;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_busy <= 1'b0; pp_finish <= 1'b1; pp_T <= '0; pp_cnt <= 0; pp_m_lat <= '0;
    end else if (pp_busy) begin
      if (pp_cnt == 0) begin
        pp_busy <= 1'b0; pp_finish <= 1'b1; pp_T <= pre_t(pp_m_lat, cur_n);
      end else pp_cnt <= pp_cnt - 1;
    end else if (pp_start) begin
      pp_busy <= 1'b1; pp_finish <= 1'b0; pp_cnt <= PP_LAT - 1; pp_m_lat <= pp_M;
    end
  end

  // ---------------- behavioural Montgomery multiplier ----------------
  logic         mm_busy;
  int           mm_cnt;
  logic [W-1:0] mm_a_lat, mm_b_lat;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_busy <= 1'b0; mm_done <= 1'b0; mm_p <= '0; mm_cnt <= 0; mm_a_lat <= '0; mm_b_lat <= '0;
    end else begin
      mm_done <= 1'b0;
      if (mm_busy) begin
        if (mm_cnt == 0) begin
          mm_busy <= 1'b0; mm_done <= 1'b1; mm_p <= mont(mm_a_lat, mm_b_lat, cur_n);
        end else mm_cnt <= mm_cnt - 1;
      end else if (mm_start) begin
        mm_busy <= 1'b1; mm_cnt <= MM_LAT - 1; mm_a_lat <= mm_a; mm_b_lat <= mm_b;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int op_cnt = 0;
  int diff_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pp_start) begin
        op_cnt = 0;
        diff_cnt = 0;
        chk("pp_M_latched_y", pp_M, cur_y);
      end
      if (mm_start) begin
        op_cnt++;
        if (mm_a != mm_b) diff_cnt++;
        chk("mm_no_overlap", W'(mm_busy), W'(0));
      end
      if (mm_done) begin
        chk("mm_a_stable", mm_a, mm_a_lat);
        chk("mm_b_stable", mm_b, mm_b_lat);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          logic [W-1:0] er;
          int eo, ed;
          er = exp_q.pop_front();
          eo = ops_q.pop_front();
          ed = diff_q.pop_front();
          chk("result", result_o, er);
          chk("busy_low_at_done", W'(busy), W'(0));
          chk_int("mm_ops", op_cnt, eo);
          if (ed >= 0) chk_int("mm_mul_ops", diff_cnt, ed);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] n, y, d, input int diff);
    cur_n = n;
    cur_y = y;
    exp_q.push_back(mod_exp(y, d, n));
    ops_q.push_back($countones(d) + EB - 1);
    diff_q.push_back(diff);
    @(negedge clk);
    n_in = n; y_in = y; d_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", W'(busy), W'(1));
    chk("pp_start_pulse", W'(pp_start), W'(1));
    n_in = rand_w(); y_in = rand_w(); d_in = rand_w();
  endtask

  task automatic run_op(input logic [W-1:0] n, y, d, input int diff, input bit pester);
    bit seen;
    issue(n, y, d, diff);
    seen = 1'b0;
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (pester && $urandom_range(0, 499) == 0) begin
        start = 1'b1; n_in = rand_w(); y_in = rand_w(); d_in = rand_w();
      end
    end
    chk_int("done_within_budget", int'(seen), 1);
    @(negedge clk);
  endtask

  task automatic run_abort(input logic [W-1:0] n, y, d);
    bit seen;
    bit noisy;
    issue(n, y, d, -1);
    seen = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (mm_start && mm_a == mm_b) begin
        seen = 1'b1;
        break;
      end
    end
    chk_int("square_reached", int'(seen), 1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_mm_start", W'(mm_start), W'(0));
    chk("abort_mm_a", mm_a, W'(0));
    chk("abort_mm_b", mm_b, W'(0));
    chk("abort_result", result_o, W'(0));
    chk("abort_pp_M", pp_M, W'(0));
    void'(exp_q.pop_back());
    void'(ops_q.pop_back());
    void'(diff_q.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    noisy = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (pp_start || mm_start || done) noisy = 1'b1;
    end
    chk_int("quiet_after_reset", int'(noisy), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] n, y, d;
    repeat (3) @(negedge clk);
    chk("rst_result", result_o, W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_pp_start", W'(pp_start), W'(0));
    chk("rst_mm_start", W'(mm_start), W'(0));
    chk("rst_mm_a", mm_a, W'(0));
    chk("rst_pp_M", pp_M, W'(0));
    chk("rst_state", W'(state_o), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op(W'(143), W'(2), W'(7), 3, 1'b0);
    run_op(W'(143), W'(142), W'(2), 1, 1'b0);
    run_op(W'(143), W'($urandom_range(1, 142)), W'(0), 0, 1'b0);

    n = rand_w(); n[0] = 1'b1; n[W-1] = 1'b1;
    y = rand_w() % n;
    run_op(n, y, {W{1'b1}}, -1, 1'b0);

    n = rand_w(); n[0] = 1'b1; n[W-1] = 1'b1;
    y = rand_w() % n;
    d = rand_w() & rand_w();
    run_op(n, y, d, -1, 1'b1);

    n = rand_w(); n[0] = 1'b1;
    y = rand_w() % n;
    run_abort(n, y, rand_w());

    n = rand_w(); n[0] = 1'b1; n[W-1] = 1'b1;
    y = rand_w() % n;
    d = rand_w() & rand_w() & rand_w();
    run_op(n, y, d, -1, 1'b0);

    repeat (5) @(negedge clk);
    chk_int("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
